// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier with valid/ready flow control.
// Optional macro FP_MUL_FLAGS_EN adds a flags[3:0] = {invalid, overflow, underflow, inexact} output.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data1,
  input  logic [W-1:0]     data2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [W-1:0]     datanew,
  output logic [TAG_W-1:0] tag_out,
  output logic             output_update,
  input  logic             output_ready
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W + 2)'(EMAX);
  localparam logic signed [EXP_W+1:0] ZERO_S = '0;

  // Round-to-nearest-even; returns {carry, fraction} with the carry already renormalised.
  function automatic logic [MAN_W:0] rne_round(input logic [MAN_W:0] mant,
                                               input logic guard, input logic sticky);
    logic               round_up;
    logic [MAN_W+1:0]   sum;
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + (MAN_W + 2)'(round_up);
    return sum[MAN_W+1] ? {1'b1, sum[MAN_W:1]} : {1'b0, sum[MAN_W-1:0]};
  endfunction

  function automatic logic [W-1:0] saturate_pack(input logic sign_in,
                                                 input logic signed [EXP_W+1:0] exp_in,
                                                 input logic [MAN_W-1:0] frac_in,
                                                 input logic nan_in, input logic inf_in,
                                                 input logic zero_in);
    if (nan_in)
      return {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
    else if (inf_in || (!zero_in && exp_in >= EMAX_S))
      return {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero_in || exp_in <= ZERO_S)
      return {sign_in, {(EXP_W + MAN_W){1'b0}}};
    else
      return {sign_in, exp_in[EXP_W-1:0], frac_in};
  endfunction

  logic ld_p0, ld_p1, ld_p2;
  logic vld_p0, vld_p1, vld_p2;

  assign ld_p2       = ~vld_p2 | output_ready;
  assign ld_p1       = ~vld_p1 | ld_p2;
  assign ld_p0       = ~vld_p0 | ld_p1;
  assign input_ready = ld_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= input_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: unpack, classify, exponent sum, significand product ----
  logic                    sign_a, sign_b;
  logic [EXP_W-1:0]        exp_a, exp_b;
  logic [MAN_W-1:0]        frac_a, frac_b;
  logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [MAN_W:0]          sig_a, sig_b;
  logic                    nan_s1, inf_s1, zero_s1;
  logic signed [EXP_W+1:0] exp_sum_s1;
  logic [PW-1:0]           prod_s1;

  assign {sign_a, exp_a, frac_a} = data1;
  assign {sign_b, exp_b, frac_b} = data2;

  // A zero exponent field covers both true zero and flushed subnormals.
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == '1) && (frac_a == '0);
  assign inf_b  = (exp_b == '1) && (frac_b == '0);
  assign nan_a  = (exp_a == '1) && (frac_a != '0);
  assign nan_b  = (exp_b == '1) && (frac_b != '0);

  assign sig_a      = zero_a ? '0 : {1'b1, frac_a};
  assign sig_b      = zero_b ? '0 : {1'b1, frac_b};
  assign prod_s1    = PW'(sig_a) * PW'(sig_b);
  assign exp_sum_s1 = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

  assign nan_s1  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
  assign inf_s1  = (inf_a | inf_b) & ~nan_s1;
  assign zero_s1 = (zero_a | zero_b) & ~nan_s1;

  logic                    sign_p0, nan_p0, inf_p0, zero_p0;
  logic signed [EXP_W+1:0] exp_p0;
  logic [PW-1:0]           prod_p0;
  logic [TAG_W-1:0]        tag_p0;

  // ---- Stage 2: normalise and round ----
  logic                    msb_s2, guard_s2, sticky_s2;
  logic [PW-1:0]           norm_s2;
  logic [MAN_W:0]          rnd_s2;
  logic signed [EXP_W+1:0] exp_s2;

  assign msb_s2    = prod_p0[PW-1];
  assign norm_s2   = msb_s2 ? prod_p0 : (prod_p0 << 1);
  assign guard_s2  = norm_s2[MAN_W];
  assign sticky_s2 = |norm_s2[MAN_W-1:0];
  assign rnd_s2    = rne_round(norm_s2[PW-1 -: MAN_W+1], guard_s2, sticky_s2);
  assign exp_s2    = exp_p0 + $signed((EXP_W + 2)'(msb_s2))
                            + $signed((EXP_W + 2)'(rnd_s2[MAN_W]));

  logic                    sign_p1, nan_p1, inf_p1, zero_p1;
  logic signed [EXP_W+1:0] exp_p1;
  logic [MAN_W-1:0]        frac_p1;
  logic [TAG_W-1:0]        tag_p1;

  // ---- Stage 3: saturate, override specials, pack ----
  logic [W-1:0]     res_s3;
  logic [W-1:0]     res_p2;
  logic [TAG_W-1:0] tag_p2;

  assign res_s3 = saturate_pack(sign_p1, exp_p1, frac_p1, nan_p1, inf_p1, zero_p1);

`ifdef FP_MUL_FLAGS_EN
  logic       uf_s1, uf_p0, uf_p1, inex_p1;
  logic       fin_s3, ovf_s3, unf_s3;
  logic [3:0] flags_s3, flags_p2;

  // Both operands nonzero but the product collapsed to zero via a flushed subnormal.
  assign uf_s1    = zero_s1 & (|{exp_a, frac_a}) & (|{exp_b, frac_b});
  assign fin_s3   = ~nan_p1 & ~inf_p1 & ~zero_p1;
  assign ovf_s3   = fin_s3 & (exp_p1 >= EMAX_S);
  assign unf_s3   = (fin_s3 & (exp_p1 <= ZERO_S)) | uf_p1;
  assign flags_s3 = {nan_p1, ovf_s3, unf_s3, (fin_s3 & inex_p1) | ovf_s3 | unf_s3};
  assign flags    = flags_p2;

  always_ff @(posedge clk) begin
    if (ld_p0 & input_valid) uf_p0 <= uf_s1;
    if (ld_p1 & vld_p0) begin
      uf_p1   <= uf_p0;
      inex_p1 <= guard_s2 | sticky_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               flags_p2 <= '0;
    else if (ld_p2 & vld_p1) flags_p2 <= flags_s3;
  end
`endif

  always_ff @(posedge clk) begin
    if (ld_p0 & input_valid) begin
      sign_p0 <= sign_a ^ sign_b;
      exp_p0  <= exp_sum_s1;
      prod_p0 <= prod_s1;
      nan_p0  <= nan_s1;
      inf_p0  <= inf_s1;
      zero_p0 <= zero_s1;
      tag_p0  <= tag_in;
    end
    if (ld_p1 & vld_p0) begin
      sign_p1 <= sign_p0;
      exp_p1  <= exp_s2;
      frac_p1 <= rnd_s2[MAN_W-1:0];
      nan_p1  <= nan_p0;
      inf_p1  <= inf_p0;
      zero_p1 <= zero_p0;
      tag_p1  <= tag_p0;
    end
  end

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_p2 <= '0;
      tag_p2 <= '0;
    end else if (ld_p2 & vld_p1) begin
      res_p2 <= res_s3;
      tag_p2 <= tag_p1;
    end
  end

  assign datanew       = res_p2;
  assign tag_out       = tag_p2;
  assign output_update = vld_p2;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: real-arithmetic reference model, in-order scoreboard, directed and random ops.
// Covers FP16 default build and a bfloat16 instance; flags are compared when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data1 = '0, data2 = '0;
  logic [3:0]  tag_in = '0;
  logic        input_valid = 1'b0;
  logic        output_ready = 1'b1;
  logic        input_ready;
  logic [15:0] datanew;
  logic [3:0]  tag_out;
  logic        output_update;

  logic [15:0] b_d1 = '0, b_d2 = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_upd;
  logic [15:0] b_dout;
  logic [3:0]  b_tag;

`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags, b_flags;
`endif

  fp_mul_pipe u_dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .tag_in(tag_in),
    .input_valid(input_valid), .input_ready(input_ready), .datanew(datanew),
    .tag_out(tag_out), .output_update(output_update), .output_ready(output_ready)
`ifdef FP_MUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7)) u_bf (
    .clk(clk), .rst(rst), .data1(b_d1), .data2(b_d2), .tag_in(4'h0),
    .input_valid(b_valid), .input_ready(b_ready), .datanew(b_dout),
    .tag_out(b_tag), .output_update(b_upd), .output_ready(1'b1)
`ifdef FP_MUL_FLAGS_EN
    , .flags(b_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  tag;
    logic [3:0]  fl;
    logic [15:0] lit;
    logic        has_lit;
    logic        lat_chk;
    int          cyc;
  } ent_t;

  ent_t        sb[$];
  ent_t        m_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] held_d = '0;
  logic [3:0]  held_t = '0;
  logic [15:0] cur_lit = '0;
  logic        cur_has = 1'b0;
  logic        cur_lat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
    else        for (int i = 0; i < -n; i++) v = v / 2.0;
    return v;
  endfunction

  // Reference: decode, multiply exactly in double precision, then round-to-nearest-even.
  task automatic fp_model(input int ew, input int mw, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [3:0] fl);
    int   emax, bias, ea, eb, fa, fb, e, ip, be;
    logic s;
    real  m, sc, rem;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s    = a[15] ^ b[15];
    ea   = (int'(a) >> mw) & emax;
    eb   = (int'(b) >> mw) & emax;
    fa   = int'(a) & ((1 << mw) - 1);
    fb   = int'(b) & ((1 << mw) - 1);
    fl   = 4'b0000;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
        (ea == emax && eb == 0) || (eb == emax && ea == 0)) begin
      r  = 16'((emax << mw) | (1 << (mw - 1)));
      fl = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      r = {s, 15'(emax << mw)};
    end else if (ea == 0 || eb == 0) begin
      r = {s, 15'd0};
      if ((ea != 0 || fa != 0) && (eb != 0 || fb != 0)) fl = 4'b0011;
    end else begin
      m = (1.0 + real'(fa) / real'(1 << mw)) * pow2(ea - bias) *
          (1.0 + real'(fb) / real'(1 << mw)) * pow2(eb - bias);
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      sc  = m * real'(1 << mw);
      ip  = $rtoi(sc);
      rem = sc - real'(ip);
      if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
      if (ip == (1 << (mw + 1))) begin ip = ip / 2; e++; end
      be = e + bias;
      if (be >= emax) begin
        r = {s, 15'(emax << mw)}; fl = 4'b0101;
      end else if (be <= 0) begin
        r = {s, 15'd0}; fl = 4'b0011;
      end else begin
        r  = {s, 15'((be << mw) | (ip - (1 << mw)))};
        fl = (rem != 0.0) ? 4'b0001 : 4'b0000;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_update", {31'd0, output_update}, 32'd1);
        chk("stall_data", {16'd0, datanew}, {16'd0, held_d});
        chk("stall_tag", {28'd0, tag_out}, {28'd0, held_t});
      end
      if (output_update && output_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got 0x%0h tag %0d required no output", datanew, tag_out);
        end else begin
          m_e = sb.pop_front();
          chk("result", {16'd0, datanew}, {16'd0, m_e.r});
          chk("tag", {28'd0, tag_out}, {28'd0, m_e.tag});
`ifdef FP_MUL_FLAGS_EN
          chk("flags", {28'd0, flags}, {28'd0, m_e.fl});
`endif
          if (m_e.has_lit) chk("literal", {16'd0, datanew}, {16'd0, m_e.lit});
          if (m_e.lat_chk) chk("latency", cyc - m_e.cyc, 32'd3);
          n_out++;
        end
      end
      prev_stall = output_update && !output_ready;
      held_d = datanew;
      held_t = tag_out;
      if (input_valid && input_ready) begin
        fp_model(5, 10, data1, data2, m_e.r, m_e.fl);
        m_e.tag = tag_in; m_e.lit = cur_lit; m_e.has_lit = cur_has;
        m_e.lat_chk = cur_lat; m_e.cyc = cyc;
        sb.push_back(m_e);
      end
    end
  end

  // Present one op and hold it until accepted; force output_ready high after force_after stalled cycles.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                      input logic [15:0] lit, input logic has_lit, input logic lat, input int force_after);
    int w;
    data1 = a; data2 = b; tag_in = t;
    cur_lit = lit; cur_has = has_lit; cur_lat = lat;
    input_valid = 1'b1;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (input_ready) break;
      w++;
      if (w > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: got input_ready 0 for %0d cycles required 1", w);
        break;
      end
      @(posedge clk); #1;
      if (w >= force_after) output_ready = 1'b1;
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic bf_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] lit);
    logic [15:0] r;
    logic [3:0]  fl;
    logic        got;
    fp_model(8, 7, a, b, r, fl);
    b_d1 = a; b_d2 = b; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_upd) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL bf_timeout: got no output_update required one within 10 cycles");
    end else begin
      chk("bf_literal", {16'd0, b_dout}, {16'd0, lit});
      chk("bf_model", {16'd0, b_dout}, {16'd0, r});
`ifdef FP_MUL_FLAGS_EN
      chk("bf_flags", {28'd0, b_flags}, {28'd0, fl});
`endif
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] mr, ra, rb;
    logic [3:0]  mf;
    int          out0;

    fp_model(5, 10, 16'h5BF0, 16'h47AF, mr, mf); chk("model_5bf0", {16'd0, mr}, 32'h67A0);
    fp_model(5, 10, 16'h3C01, 16'h3FFF, mr, mf); chk("model_tie", {16'd0, mr}, 32'h4000);
    fp_model(5, 10, 16'h7BFF, 16'h4000, mr, mf); chk("model_ovf", {12'd0, mf, mr}, 32'h5_7C00);
    fp_model(5, 10, 16'h0400, 16'h3800, mr, mf); chk("model_unf", {12'd0, mf, mr}, 32'h3_0000);
    fp_model(8, 7, 16'h7F7F, 16'h4000, mr, mf);  chk("model_bf_ovf", {16'd0, mr}, 32'h7F80);

    #2 rst = 1'b0;
    #1;
    chk("reset_update", {31'd0, output_update}, 32'd0);
    chk("reset_data", {16'd0, datanew}, 32'd0);
    chk("reset_tag", {28'd0, tag_out}, 32'd0);
    chk("reset_in_ready", {31'd0, input_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    send(16'h5BF0, 16'h47AF, 4'd1, 16'h67A0, 1'b1, 1'b1, 1000);
    send(16'h4440, 16'h4660, 4'd2, 16'h4EC6, 1'b1, 1'b1, 1000);
    send(16'h7BFF, 16'h4000, 4'd3, 16'h7C00, 1'b1, 1'b0, 1000);
    send(16'h0000, 16'h7C00, 4'd4, 16'h7E00, 1'b1, 1'b0, 1000);
    send(16'hC000, 16'h3C00, 4'd5, 16'hC000, 1'b1, 1'b0, 1000);
    send(16'h0400, 16'h3800, 4'd6, 16'h0000, 1'b1, 1'b0, 1000);
    send(16'h3C01, 16'h3FFF, 4'd7, 16'h4000, 1'b1, 1'b0, 1000);
    send(16'h7C00, 16'hC000, 4'd8, 16'hFC00, 1'b1, 1'b0, 1000);
    send(16'h7E01, 16'h3C00, 4'd9, 16'h7E00, 1'b1, 1'b0, 1000);
    send(16'h8001, 16'h4000, 4'd10, 16'h8000, 1'b1, 1'b0, 1000);
    repeat (6) @(posedge clk);
    #1;

    out0 = n_out;
    output_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'h3C00 + 16'(i * 64), 16'h4100, 4'(i), 16'h0, 1'b0, 1'b0, 1000);
    data1 = 16'h3C00 + 16'(3 * 64); data2 = 16'h4100; tag_in = 4'd3; input_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, input_ready}, 32'd0);
      @(posedge clk); #1;
    end
    output_ready = 1'b1;
    for (int i = 3; i < 6; i++)
      send(16'h3C00 + 16'(i * 64), 16'h4100, 4'(i), 16'h0, 1'b0, 1'b0, 1000);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_count", n_out - out0, 32'd6);
    chk("bp_queue_empty", sb.size(), 32'd0);

    output_ready = 1'b0;
    send(16'h4000, 16'h4000, 4'd11, 16'h4400, 1'b1, 1'b0, 1000);
    send(16'h4200, 16'h4000, 4'd12, 16'h4600, 1'b1, 1'b0, 1000);
    @(posedge clk); #1;
    chk("rst_pre_update", {31'd0, output_update}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_update", {31'd0, output_update}, 32'd0);
    chk("rst_async_data", {16'd0, datanew}, 32'd0);
    chk("rst_async_tag", {28'd0, tag_out}, 32'd0);
    sb.delete();
    output_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_no_output", {31'd0, output_update}, 32'd0);
    end
    @(posedge clk); #1;
    send(16'h3C00, 16'h3C00, 4'd13, 16'h3C00, 1'b1, 1'b1, 1000);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_queue_empty", sb.size(), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      output_ready = ($urandom_range(0, 3) != 0);
      send(ra, rb, 4'(i), 16'h0, 1'b0, 1'b0, 1);
    end
    output_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("random_queue_empty", sb.size(), 32'd0);

    bf_op(16'h4040, 16'h4000, 16'h40C0);
    bf_op(16'h7F7F, 16'h4000, 16'h7F80);
    bf_op(16'h3F80, 16'hBF80, 16'hBF80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
